// File: rtl/bus_split.sv
// Single-master to N-slave splitter: registered one-cycle request, response routed back with m_ready.
// Latency 2 cycles (combinational-ready slave) to 3+ cycles; watchdog and unmapped decode end in ERR_DATA.
module bus_split #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                N_SLAVES  = 4,
    parameter int                SEL_W     = 2,
    parameter int                TIMEOUT_W = 8,
    parameter int                TIMEOUT   = 200,
    parameter logic [DATA_W-1:0] ERR_DATA  = 32'hDEADBEEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m_valid,
    input  logic [ADDR_W-1:0]            m_address,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic [DATA_W/8-1:0]          m_wstrb,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_ready,
    output logic [N_SLAVES-1:0]          s_valid,
    output logic [ADDR_W-1:0]            s_address,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_wstrb,
    input  logic [N_SLAVES*DATA_W-1:0]   s_rdata,
    input  logic [N_SLAVES-1:0]          s_ready,
    output logic                         err,
    output logic [SEL_W-1:0]             err_sel
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_t;

    localparam logic [SEL_W:0]       NS_LIM  = (SEL_W+1)'(N_SLAVES);
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SEL_W-1:0]       r_sel_q;
    logic [TIMEOUT_W-1:0]   r_timer;
    logic [ADDR_W-1:0]      r_address;
    logic [DATA_W-1:0]      r_wdata;
    logic [DATA_W/8-1:0]    r_wstrb;
    logic [DATA_W-1:0]      r_rdata;
    logic                   r_err;
    logic [SEL_W-1:0]       r_err_sel;

    logic [SEL_W-1:0]       w_m_sel;
    logic                   w_mapped;
    logic                   w_accept;
    logic                   w_capture;
    logic                   w_load_err;
    logic [SEL_W-1:0]       w_err_sel_nxt;
    logic                   w_timer_clr;
    logic                   w_timer_inc;
    logic                   w_sel_ready;
    logic [DATA_W-1:0]      w_sel_rdata;
    logic [N_SLAVES-1:0]    w_s_valid;

    assign w_m_sel  = m_address[ADDR_W-1 -: SEL_W];
    assign w_mapped = {1'b0, w_m_sel} < NS_LIM;

    // Only the selected slave's ready/rdata is ever looked at.
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
        w_s_valid   = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (r_sel_q == SEL_W'(k)) begin
                w_sel_ready  = s_ready[k];
                w_sel_rdata  = s_rdata[k*DATA_W +: DATA_W];
                w_s_valid[k] = (r_state == ST_REQ);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_capture     = 1'b0;
        w_load_err    = 1'b0;
        w_err_sel_nxt = r_sel_q;
        w_timer_clr   = 1'b0;
        w_timer_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (m_valid) begin
                    w_accept = 1'b1;
                    if (w_mapped) begin
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_load_err    = 1'b1;
                        w_err_sel_nxt = w_m_sel;
                        w_state_nxt   = ST_RESP;
                    end
                end
            end
            ST_REQ: begin
                if (w_sel_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_timer_clr = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_sel_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (r_timer == TO_LAST) begin
                    w_load_err  = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_timer_inc = 1'b1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request fields stay frozen until the next accept; slaves may decode them while ready is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_address <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_sel_q   <= '0;
            r_rdata   <= '0;
            r_timer   <= '0;
            r_err     <= 1'b0;
            r_err_sel <= '0;
        end else begin
            if (w_accept) begin
                r_address <= m_address;
                r_wdata   <= m_wdata;
                r_wstrb   <= m_wstrb;
                r_sel_q   <= w_m_sel;
            end
            if (w_capture) begin
                r_rdata <= w_sel_rdata;
            end else if (w_load_err) begin
                r_rdata <= ERR_DATA;
            end
            if (w_load_err) begin
                r_err     <= 1'b1;
                r_err_sel <= w_err_sel_nxt;
            end
            if (w_timer_clr) begin
                r_timer <= '0;
            end else if (w_timer_inc) begin
                r_timer <= r_timer + TIMEOUT_W'(1);
            end
        end
    end

    assign s_valid   = w_s_valid;
    assign s_address = r_address;
    assign s_wdata   = r_wdata;
    assign s_wstrb   = r_wstrb;
    assign m_rdata   = r_rdata;
    assign m_ready   = (r_state == ST_RESP);
    assign err       = r_err;
    assign err_sel   = r_err_sel;

endmodule

// File: tb/tb_bus_split.sv
// Directed bench for bus_split: four-slave instance (comb, ID, silent, spurious) plus a three-slave instance for unmapped decode.
module tb_bus_split;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    always #5 clk = ~clk;

    // Four-slave instance
    logic         m_valid = 1'b0;
    logic [31:0]  m_address = '0;
    logic [31:0]  m_wdata = '0;
    logic [3:0]   m_wstrb = '0;
    logic [31:0]  m_rdata;
    logic         m_ready;
    logic [3:0]   s_valid;
    logic [31:0]  s_address;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic [127:0] s_rdata;
    logic [3:0]   s_ready;
    logic         err;
    logic [1:0]   err_sel;

    logic         s3_spur = 1'b0;
    int           s1_lat = 1;
    int           s1_cnt = 0;
    int           spur_at = -1;

    assign s_rdata = {32'h3333_3333, 32'h2222_2222, 32'h0000_00A5, 32'h1234_5678};
    assign s_ready = {s3_spur, 1'b0, (s1_cnt == 1), s_valid[0]};

    // Slave 1 answers s1_lat cycles after its request
    always @(posedge clk) begin
        if (s_valid[1]) s1_cnt <= s1_lat;
        else if (s1_cnt != 0) s1_cnt <= s1_cnt - 1;
    end

    bus_split #(.N_SLAVES(4), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .s_valid(s_valid), .s_address(s_address), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .err(err), .err_sel(err_sel)
    );

    // Three-slave instance
    logic         b_m_valid = 1'b0;
    logic [31:0]  b_m_address = '0;
    logic [31:0]  b_m_rdata;
    logic         b_m_ready;
    logic [2:0]   b_s_valid;
    logic [31:0]  b_s_address;
    logic [31:0]  b_s_wdata;
    logic [3:0]   b_s_wstrb;
    logic [95:0]  b_s_rdata;
    logic [2:0]   b_s_ready;
    logic         b_err;
    logic [1:0]   b_err_sel;

    assign b_s_rdata = {3{32'h0000_0077}};
    assign b_s_ready = b_s_valid;

    bus_split #(.N_SLAVES(3), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst),
        .m_valid(b_m_valid), .m_address(b_m_address), .m_wdata(32'h0), .m_wstrb(4'h0),
        .m_rdata(b_m_rdata), .m_ready(b_m_ready),
        .s_valid(b_s_valid), .s_address(b_s_address), .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb),
        .s_rdata(b_s_rdata), .s_ready(b_s_ready),
        .err(b_err), .err_sel(b_err_sel)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Results of the last transaction
    int           t_rdy;
    logic [31:0]  t_rdata;
    int           t_sv_first;
    logic [3:0]   t_sv_val;
    int           t_sv_cnt;
    logic [31:0]  t_sv_addr;
    logic [31:0]  t_sv_wdata;
    logic [3:0]   t_sv_wstrb;

    // Called at posedge+1; cycle 0 is the cycle whose closing edge samples m_valid.
    task automatic txn(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws);
        t_rdy = -1; t_rdata = '0; t_sv_first = -1; t_sv_val = '0; t_sv_cnt = 0;
        t_sv_addr = '0; t_sv_wdata = '0; t_sv_wstrb = '0;
        m_address = addr; m_wdata = wd; m_wstrb = ws; m_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            s3_spur = (c == spur_at);
            if (s_valid != 4'b0) begin
                if (t_sv_first < 0) begin
                    t_sv_first = c; t_sv_val = s_valid;
                    t_sv_addr = s_address; t_sv_wdata = s_wdata; t_sv_wstrb = s_wstrb;
                end
                t_sv_cnt++;
            end
            if (m_ready) begin
                t_rdy = c; t_rdata = m_rdata;
                m_valid = 1'b0; s3_spur = 1'b0;
                break;
            end
        end
        m_valid = 1'b0;
        s3_spur = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int b_rdy;
        int b_sv;
        logic [31:0] b_rd;

        #3;
        chk("rst_s_valid", s_valid, 4'b0);
        chk("rst_m_ready", m_ready, 1'b0);
        chk("rst_m_rdata", m_rdata, 32'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_err_sel", err_sel, 2'd0);
        chk("rst_s_address", s_address, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // ID slave read, registered ready
        txn(32'h4000_0000, 32'h0, 4'h0);
        chk("id_sv_cycle", t_sv_first, 1);
        chk("id_sv_val", t_sv_val, 4'b0010);
        chk("id_sv_count", t_sv_cnt, 1);
        chk("id_sv_addr", t_sv_addr, 32'h4000_0000);
        chk("id_rdy_cycle", t_rdy, 3);
        chk("id_rdata", t_rdata, 32'h0000_00A5);
        chk("id_err", err, 1'b0);

        // Combinational-ready slave 0, write
        txn(32'h0000_0010, 32'hCAFE_F00D, 4'b1010);
        chk("comb_rdy_cycle", t_rdy, 2);
        chk("comb_rdata", t_rdata, 32'h1234_5678);
        chk("comb_sv_val", t_sv_val, 4'b0001);
        chk("comb_wdata", t_sv_wdata, 32'hCAFE_F00D);
        chk("comb_wstrb", t_sv_wstrb, 4'b1010);
        chk("hold_s_address", s_address, 32'h0000_0010);

        // Silent slave 2 -> watchdog
        txn(32'h8000_0004, 32'h0, 4'h0);
        chk("to_rdy_cycle", t_rdy, 10);
        chk("to_rdata", t_rdata, 32'hDEAD_BEEF);
        chk("to_err", err, 1'b1);
        chk("to_err_sel", err_sel, 2'd2);
        chk("to_sv_cnt", t_sv_cnt, 1);
        chk("hold_m_rdata", m_rdata, 32'hDEAD_BEEF);

        txn(32'h0000_0000, 32'h0, 4'h0);
        chk("after_to_rdy", t_rdy, 2);
        chk("after_to_rdata", t_rdata, 32'h1234_5678);
        chk("after_to_err", err, 1'b1);
        chk("after_to_err_sel", err_sel, 2'd2);

        // Spurious s_ready[3] while slave 1 waits
        s1_lat = 4; spur_at = 3;
        txn(32'h4000_0000, 32'h0, 4'h0);
        chk("spur_rdy_cycle", t_rdy, 6);
        chk("spur_rdata", t_rdata, 32'h0000_00A5);
        s1_lat = 1; spur_at = -1;

        // Unmapped select on three-slave instance
        b_rdy = -1; b_sv = 0; b_rd = '0;
        b_m_address = 32'hC000_0000; b_m_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (b_s_valid != 3'b0) b_sv++;
            if (b_m_ready) begin
                b_rdy = c; b_rd = b_m_rdata; b_m_valid = 1'b0;
                break;
            end
        end
        b_m_valid = 1'b0;
        repeat (3) @(negedge clk) if (b_s_valid != 3'b0) b_sv++;
        chk("unmap_rdy_cycle", b_rdy, 1);
        chk("unmap_rdata", b_rd, 32'hDEAD_BEEF);
        chk("unmap_err", b_err, 1'b1);
        chk("unmap_err_sel", b_err_sel, 2'd3);
        chk("unmap_no_s_valid", b_sv, 0);
        @(posedge clk); #1;

        // Asynchronous reset while waiting on slave 2
        m_address = 32'h8000_0000; m_valid = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_s_valid", s_valid, 4'b0);
        chk("arst_m_ready", m_ready, 1'b0);
        chk("arst_err", err, 1'b0);
        chk("arst_err_sel", err_sel, 2'd0);
        chk("arst_m_rdata", m_rdata, 32'h0);
        m_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        txn(32'h4000_0000, 32'h0, 4'h0);
        chk("post_rst_rdy", t_rdy, 3);
        chk("post_rst_rdata", t_rdata, 32'h0000_00A5);
        chk("post_rst_err", err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_split.md
Name: bus_split

Overview:
- Single-master to N-slave splitter on the native CPU bus (valid/address/wdata/wstrb/rdata/ready).
- Sits directly upstream of the ID register block and the other peripherals.
- Decodes the top address bits, issues a registered one-cycle request to the selected slave and routes its rdata/ready back.
- Terminates accesses to unmapped or unresponsive slaves with an error word so the CPU never hangs.

Parameters:
- DATA_W, 32, data width.
- ADDR_W, 32, master address width.
- N_SLAVES, 4, number of slave ports (1..2^SEL_W).
- SEL_W, 2, number of address MSBs used as slave select.
- TIMEOUT_W, 8, width of the response watchdog counter.
- TIMEOUT, 200, cycles waited in WAIT before forced error (must be less than 2^TIMEOUT_W).
- ERR_DATA, 32'hDEADBEEF, rdata returned on error.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- m_valid  in  1  master request; held high until m_ready
- m_address  in  ADDR_W  master address; [ADDR_W-1 -: SEL_W] selects slave
- m_wdata  in  DATA_W  write data
- m_wstrb  in  DATA_W/8  byte write strobes; 0 = read
- m_rdata  out  DATA_W  read data, valid while m_ready=1
- m_ready  out  1  one-cycle completion pulse
- s_valid  out  N_SLAVES  one-hot request, one bit per slave
- s_address  out  ADDR_W  registered address, shared by all slaves
- s_wdata  out  DATA_W  registered write data, shared
- s_wstrb  out  DATA_W/8  registered strobes, shared
- s_rdata  in  N_SLAVES*DATA_W  slave k read data at [k*DATA_W +: DATA_W]
- s_ready  in  N_SLAVES  slave completion
- err  out  1  sticky error flag
- err_sel  out  SEL_W  select value of the most recent errored access

Behaviour:
- Reset (asynchronous, any state): state=IDLE; s_valid=0; m_ready=0; m_rdata=0; s_address/s_wdata/s_wstrb=0; sel_q=0; timer=0; err=0; err_sel=0. A transaction in flight is dropped with no response.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - m_valid=1 → register address, wdata, wstrb and sel_q=m_address[ADDR_W-1 -: SEL_W].
  - If sel_q < N_SLAVES → next state REQ.
  - Otherwise → RESP with m_rdata=ERR_DATA, err=1, err_sel=sel.
- REQ:
  - s_valid[sel_q]=1 for exactly this cycle; all other s_valid bits are 0.
  - s_ready[sel_q]=1 in the same cycle → capture s_rdata[sel_q], next state RESP.
  - Otherwise → WAIT, timer=0.
- WAIT:
  - s_valid=0.
  - s_ready[sel_q]=1 → capture rdata, next state RESP.
  - Else timer increments each cycle. When timer==TIMEOUT-1 with no ready → m_rdata=ERR_DATA, err=1, err_sel=sel_q, next state RESP.
- RESP: m_ready=1 for one cycle, m_rdata stable; next state IDLE unconditionally.
- The master drops m_valid by the edge that ends the m_ready cycle. IDLE re-accepts on the following edge, giving a back-to-back rate of one access per 4 cycles minimum.
- Latency:
  - Slave that registers ready one cycle after valid (the ID block): m_valid sampled at edge 0, m_ready high in cycle 3.
  - Combinational-ready slave: m_ready high in cycle 2.
- s_ready from non-selected slaves is ignored in every state. s_ready in IDLE or RESP is ignored.
- s_address/s_wdata/s_wstrb stay constant from REQ until the next IDLE accept, because the ID block decodes address combinationally while ready is high.
- m_rdata holds its value after RESP until the next capture. It is meaningful only while m_ready=1.
- err and err_sel are cleared only by rst. A later error overwrites err_sel.
- Writes (m_wstrb≠0) follow the identical sequence; the returned rdata is whatever the slave drives.

Test Plan:
- Read ID slave (slot 1 of 4, ID=32'h0000_00A5): m_valid with m_address=32'h4000_0000 → s_valid=4'b0010 exactly one cycle (cycle 1); m_ready in cycle 3 with m_rdata=32'hA5; err=0.
- Combinational-ready slave 0: s_ready[0] tied to s_valid[0], s_rdata=32'h1234_5678, m_address=0 → m_ready in cycle 2, m_rdata=32'h1234_5678.
- Timeout: slave 2 never responds, TIMEOUT=8 → m_ready at cycle 1+8+1=10, m_rdata=32'hDEADBEEF, err=1, err_sel=2; next access to slave 0 completes normally with err still 1.
- Unmapped select with N_SLAVES=3: m_address=32'hC000_0000 → no s_valid bit ever set; m_ready in cycle 1 with ERR_DATA; err_sel=3.
- Spurious ready: s_ready[3] pulsed while slave 1 is selected and in WAIT → ignored; completion occurs only on s_ready[1], returning slave 1 data.
- Reset mid-WAIT: assert rst asynchronously → s_valid, m_ready and err go to 0 immediately; after release, a fresh read of the ID slave completes in 3 cycles.
